// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency SRAM backing store for the data bus.
// 64-bit word array, byte-strobed writes, out-of-range answers 0 with err.
package dbus_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_sram_responder
   import dbus_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       busy,
   output logic       err
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
   localparam logic [3:0] CNT_INIT =
      (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [63:0]      mem [DEPTH];

   logic [IDX_W-1:0] idx_q;
   logic             in_range_q;
   logic [7:0]       strobe_q;
   logic [63:0]      wdata_q;

   logic [63:0]      req_off;
   logic [IDX_W-1:0] req_idx;
   logic             req_in_range;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_in_range;
   logic             enter_resp;
   logic             wr_en;
   logic             unused_size;

   assign unused_size = ^dreq.size;

   assign req_off      = dreq.addr - BASE_ADDR;
   assign req_idx      = req_off[IDX_W+2:3];
   assign req_in_range = (dreq.addr >= BASE_ADDR)
                       && (req_off < SPAN);

   // With zero latency the word is read in the accept cycle itself,
   // before the captured registers are loaded.
   always_comb begin
      rd_idx      = idx_q;
      rd_in_range = in_range_q;
      if (state == IDLE) begin
         rd_idx      = req_idx;
         rd_in_range = req_in_range;
      end
   end

   assign enter_resp =
      ((state == IDLE) && dreq.valid && (LATENCY == 0))
      || ((state == WAIT) && dreq.valid && (cnt == 4'd0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         dresp      <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         strobe_q   <= 8'h00;
         wdata_q    <= 64'h0;
      end else begin
         dresp.addr_ok <= 1'b0;
         dresp.data_ok <= 1'b0;
         err           <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dreq.valid) begin
                  idx_q      <= req_idx;
                  in_range_q <= req_in_range;
                  strobe_q   <= dreq.strobe;
                  wdata_q    <= dreq.data;
                  busy       <= 1'b1;
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (!dreq.valid) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         if (enter_resp) begin
            dresp.addr_ok <= 1'b1;
            dresp.data_ok <= 1'b1;
            dresp.data    <= rd_in_range ? mem[rd_idx] : 64'h0;
            err           <= !rd_in_range;
         end
      end
   end

   // A write whose RESP cycle coincides with reset is dropped.
   assign wr_en = (state == RESP) && in_range_q
                && (strobe_q != 8'h00) && !reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 8; k++) begin
            if (strobe_q[k]) begin
               mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: randomized and directed checks of the responder
// against a word-array model, at LATENCY 2 and LATENCY 0.
module tb_dbus_sram_responder;
   import dbus_pkg::*;

   localparam int DEPTH = 1024;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SPAN = 64'(DEPTH) * 8;

   logic       clk = 1'b0;
   logic       reset;
   dbus_req_t  req  [2];
   dbus_resp_t resp [2];
   logic       busy [2];
   logic       err  [2];

   int errs   = 0;
   int checks = 0;

   logic [63:0] mdl [2][DEPTH];
   logic [7:0]  kb  [2][DEPTH];

   always #5 clk = ~clk;

   dbus_sram_responder #(
      .DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset(reset), .dreq(req[0]),
      .dresp(resp[0]), .busy(busy[0]), .err(err[0])
   );

   dbus_sram_responder #(
      .DEPTH(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)
   ) dut0 (
      .clk(clk), .reset(reset), .dreq(req[1]),
      .dresp(resp[1]), .busy(busy[1]), .err(err[1])
   );

   function automatic int lat(input int sel);
      return (sel == 0) ? 2 : 0;
   endfunction

   // Reference: response is the old word (0 if out of range), then bytes merge.
   task automatic model_txn(input int sel, input logic [63:0] a,
                            input logic [7:0] strb, input logic [63:0] d,
                            output logic [63:0] exp, output logic exp_err,
                            output bit exp_known);
      int idx;
      if (a < BASE || (a - BASE) >= SPAN) begin
         exp = 64'h0;
         exp_err = 1'b1;
         exp_known = 1'b1;
         return;
      end
      idx = int'((a - BASE) / 8);
      exp = mdl[sel][idx];
      exp_known = (kb[sel][idx] == 8'hFF);
      exp_err = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (strb[k]) mdl[sel][idx][8*k +: 8] = d[8*k +: 8];
      end
      kb[sel][idx] = kb[sel][idx] | strb;
   endtask

   task automatic run_txn(input int sel, input logic [63:0] a,
                          input logic [7:0] strb, input logic [63:0] d,
                          output logic [63:0] rdata, output logic rerr,
                          output logic raok, output int ok_cyc,
                          output int pulses, output logic [31:0] bmask);
      rdata = 64'h0;
      rerr = 1'b0;
      raok = 1'b0;
      ok_cyc = -1;
      pulses = 0;
      bmask = '0;
      req[sel].valid  = 1'b1;
      req[sel].addr   = a;
      req[sel].size   = 3'd3;
      req[sel].strobe = strb;
      req[sel].data   = d;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (busy[sel]) bmask[c] = 1'b1;
         if (resp[sel].data_ok) begin
            pulses++;
            if (ok_cyc < 0) begin
               ok_cyc = c;
               rdata = resp[sel].data;
               rerr = err[sel];
               raok = resp[sel].addr_ok;
            end
            req[sel].valid = 1'b0;
         end else if (ok_cyc < 0) begin
            req[sel].addr   = {$urandom, $urandom};
            req[sel].data   = {$urandom, $urandom};
            req[sel].strobe = 8'($urandom);
         end
         if (ok_cyc >= 0 && c >= ok_cyc + 2) break;
      end
      req[sel].valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req[0] = '0;
      req[1] = '0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (resp[s].data_ok !== 1'b0 || resp[s].addr_ok !== 1'b0) begin
            errs++;
            $display("FAIL reset_ok[%0d]: got %b%b want 00", s,
                     resp[s].addr_ok, resp[s].data_ok);
         end
         checks++;
         if (resp[s].data !== 64'h0) begin
            errs++;
            $display("FAIL reset_data[%0d]: got %h want 0", s, resp[s].data);
         end
         checks++;
         if (busy[s] !== 1'b0 || err[s] !== 1'b0) begin
            errs++;
            $display("FAIL reset_busy_err[%0d]: got %b%b want 00", s,
                     busy[s], err[s]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_full_write_read();
      logic [63:0] d, e;
      logic r, ee, aok;
      bit kn;
      int oc, np;
      logic [31:0] bm;
      model_txn(0, 64'h8000_0010, 8'hFF, 64'hDEADBEEF_CAFEF00D, e, ee, kn);
      run_txn(0, 64'h8000_0010, 8'hFF, 64'hDEADBEEF_CAFEF00D,
              d, r, aok, oc, np, bm);
      checks++;
      if (oc !== 3) begin
         errs++;
         $display("FAIL full_wr_latency: got %0d want 3", oc);
      end
      checks++;
      if (np !== 1) begin
         errs++;
         $display("FAIL full_wr_pulses: got %0d want 1", np);
      end
      checks++;
      if (bm !== 32'hE) begin
         errs++;
         $display("FAIL full_wr_busy: got %h want e", bm);
      end
      checks++;
      if (r !== 1'b0 || aok !== 1'b1) begin
         errs++;
         $display("FAIL full_wr_flags: got err=%b aok=%b want 0 1", r, aok);
      end
      model_txn(0, 64'h8000_0010, 8'h00, 64'h0, e, ee, kn);
      run_txn(0, 64'h8000_0010, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== e) begin
         errs++;
         $display("FAIL full_rd_data: got %h want %h", d, e);
      end
      checks++;
      if (resp[0].data !== e) begin
         errs++;
         $display("FAIL full_rd_hold: got %h want %h", resp[0].data, e);
      end
   endtask

   task automatic test_partial_strobe();
      logic [63:0] d, e;
      logic r, ee, aok;
      bit kn;
      int oc, np;
      logic [31:0] bm;
      model_txn(0, 64'h8000_0010, 8'h0F, 64'h11223344_55667788, e, ee, kn);
      run_txn(0, 64'h8000_0010, 8'h0F, 64'h11223344_55667788,
              d, r, aok, oc, np, bm);
      checks++;
      if (d !== e) begin
         errs++;
         $display("FAIL partial_old_word: got %h want %h", d, e);
      end
      model_txn(0, 64'h8000_0010, 8'h00, 64'h0, e, ee, kn);
      run_txn(0, 64'h8000_0010, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== 64'hDEADBEEF_55667788 || d !== e) begin
         errs++;
         $display("FAIL partial_merge: got %h want %h", d, e);
      end
   endtask

   task automatic test_out_of_range();
      logic [63:0] d, e, v;
      logic r, ee, aok;
      bit kn;
      int oc, np;
      logic [31:0] bm;
      v = {$urandom, $urandom};
      model_txn(0, BASE, 8'hFF, v, e, ee, kn);
      run_txn(0, BASE, 8'hFF, v, d, r, aok, oc, np, bm);
      run_txn(0, 64'h7FFF_FFF8, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== 64'h0 || r !== 1'b1 || oc !== 3) begin
         errs++;
         $display("FAIL oor_low: got data=%h err=%b cyc=%0d want 0 1 3",
                  d, r, oc);
      end
      model_txn(0, BASE + SPAN, 8'hFF, 64'h1, e, ee, kn);
      run_txn(0, BASE + SPAN, 8'hFF, 64'h1, d, r, aok, oc, np, bm);
      checks++;
      if (r !== ee) begin
         errs++;
         $display("FAIL oor_high_err: got %b want %b", r, ee);
      end
      model_txn(0, BASE, 8'h00, 64'h0, e, ee, kn);
      run_txn(0, BASE, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== e || r !== 1'b0) begin
         errs++;
         $display("FAIL oor_no_alias: got %h err=%b want %h 0", d, r, e);
      end
   endtask

   task automatic test_abort();
      logic [63:0] d, e, v;
      logic r, ee, aok;
      bit kn;
      int oc, np, pulses;
      logic [31:0] bm;
      v = {$urandom, $urandom};
      model_txn(0, BASE + 64'h20, 8'hFF, v, e, ee, kn);
      run_txn(0, BASE + 64'h20, 8'hFF, v, d, r, aok, oc, np, bm);
      req[0].valid  = 1'b1;
      req[0].addr   = BASE + 64'h20;
      req[0].strobe = 8'hFF;
      req[0].data   = ~v;
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b1) begin
         errs++;
         $display("FAIL abort_busy_c1: got %b want 1", busy[0]);
      end
      req[0].valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0) begin
         errs++;
         $display("FAIL abort_busy_c2: got %b want 0", busy[0]);
      end
      pulses = resp[0].data_ok ? 1 : 0;
      repeat (8) begin
         @(negedge clk);
         if (resp[0].data_ok) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errs++;
         $display("FAIL abort_no_resp: got %0d want 0", pulses);
      end
      model_txn(0, BASE + 64'h20, 8'h00, 64'h0, e, ee, kn);
      run_txn(0, BASE + 64'h20, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== e) begin
         errs++;
         $display("FAIL abort_no_write: got %h want %h", d, e);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d, e, v;
      logic r, ee, aok;
      bit kn;
      int oc, np;
      logic [31:0] bm;
      v = {$urandom, $urandom};
      model_txn(0, BASE + 64'h30, 8'hFF, v, e, ee, kn);
      run_txn(0, BASE + 64'h30, 8'hFF, v, d, r, aok, oc, np, bm);
      req[0].valid  = 1'b1;
      req[0].addr   = BASE + 64'h30;
      req[0].strobe = 8'hFF;
      req[0].data   = ~v;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req[0].valid = 1'b0;
      checks++;
      if (resp[0] !== '0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid_outputs: got %h b=%b e=%b want 0",
                  resp[0], busy[0], err[0]);
      end
      model_txn(0, BASE + 64'h30, 8'h00, 64'h0, e, ee, kn);
      run_txn(0, BASE + 64'h30, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== e || oc !== 3) begin
         errs++;
         $display("FAIL reset_mid_after: got %h cyc=%0d want %h 3",
                  d, oc, e);
      end
   endtask

   task automatic test_back_to_back(input int sel);
      logic [63:0] d, d1, d2, e1, e2, a, b;
      logic r, ee, aok;
      bit kn;
      int oc, np, first, second, pulses;
      logic [31:0] bm;
      a = BASE + 64'h40;
      b = BASE + 64'h48;
      d = {$urandom, $urandom};
      model_txn(sel, a, 8'hFF, d, e1, ee, kn);
      run_txn(sel, a, 8'hFF, d, d1, r, aok, oc, np, bm);
      d = {$urandom, $urandom};
      model_txn(sel, b, 8'hFF, d, e1, ee, kn);
      run_txn(sel, b, 8'hFF, d, d1, r, aok, oc, np, bm);
      model_txn(sel, a, 8'h00, 64'h0, e1, ee, kn);
      model_txn(sel, b, 8'h00, 64'h0, e2, ee, kn);
      first = -1;
      second = -1;
      pulses = 0;
      d1 = 64'h0;
      d2 = 64'h0;
      req[sel].valid  = 1'b1;
      req[sel].addr   = a;
      req[sel].strobe = 8'h00;
      req[sel].data   = 64'h0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (resp[sel].data_ok) begin
            pulses++;
            if (first < 0) begin
               first = c;
               d1 = resp[sel].data;
               req[sel].addr = b;
            end else if (second < 0) begin
               second = c;
               d2 = resp[sel].data;
               req[sel].valid = 1'b0;
            end
         end
      end
      req[sel].valid = 1'b0;
      checks++;
      if (first !== lat(sel) + 1 || second !== 2 * lat(sel) + 3) begin
         errs++;
         $display("FAIL b2b_cycles[%0d]: got %0d,%0d want %0d,%0d", sel,
                  first, second, lat(sel) + 1, 2 * lat(sel) + 3);
      end
      checks++;
      if (pulses !== 2) begin
         errs++;
         $display("FAIL b2b_pulses[%0d]: got %0d want 2", sel, pulses);
      end
      checks++;
      if (d1 !== e1 || d2 !== e2) begin
         errs++;
         $display("FAIL b2b_data[%0d]: got %h,%h want %h,%h", sel,
                  d1, d2, e1, e2);
      end
   endtask

   task automatic test_zero_latency();
      logic [63:0] d, e, v;
      logic r, ee, aok;
      bit kn;
      int oc, np;
      logic [31:0] bm;
      v = {$urandom, $urandom};
      model_txn(1, BASE + 64'h28, 8'hFF, v, e, ee, kn);
      run_txn(1, BASE + 64'h28, 8'hFF, v, d, r, aok, oc, np, bm);
      checks++;
      if (oc !== 1 || bm !== 32'h2) begin
         errs++;
         $display("FAIL zl_timing: got cyc=%0d busy=%h want 1 2", oc, bm);
      end
      model_txn(1, BASE + 64'h28, 8'h00, 64'h0, e, ee, kn);
      run_txn(1, BASE + 64'h28, 8'h00, 64'h0, d, r, aok, oc, np, bm);
      checks++;
      if (d !== e) begin
         errs++;
         $display("FAIL zl_read: got %h want %h", d, e);
      end
      test_back_to_back(1);
   endtask

   task automatic test_random();
      logic [63:0] d, e, a, dat;
      logic [7:0] strb;
      logic r, ee, aok;
      bit kn;
      int oc, np, sel, pick;
      logic [31:0] bm;
      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 9));
         if (pick == 0)
            a = BASE - 64'(8 * $urandom_range(1, 4));
         else if (pick == 1)
            a = BASE + SPAN + 64'($urandom_range(0, 255));
         else
            a = BASE + 64'($urandom_range(0, 15)) * 8
              + 64'($urandom_range(0, 7));
         strb = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         if (n < 32) strb = 8'hFF;
         dat = {$urandom, $urandom};
         model_txn(sel, a, strb, dat, e, ee, kn);
         run_txn(sel, a, strb, dat, d, r, aok, oc, np, bm);
         checks++;
         if (oc !== lat(sel) + 1 || np !== 1) begin
            errs++;
            $display("FAIL rnd_timing[%0d]: got cyc=%0d n=%0d want %0d 1",
                     n, oc, np, lat(sel) + 1);
         end
         checks++;
         if (r !== ee) begin
            errs++;
            $display("FAIL rnd_err[%0d]: got %b want %b a=%h", n, r, ee, a);
         end
         if (kn) begin
            checks++;
            if (d !== e) begin
               errs++;
               $display("FAIL rnd_data[%0d]: got %h want %h a=%h",
                        n, d, e, a);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++) kb[s][i] = 8'h00;
      test_reset();
      test_full_write_read();
      test_partial_strobe();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      test_back_to_back(0);
      test_zero_latency();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
